gray_wptr: RTL and testbench

- Write-side pointer stage of a dual-clock FIFO, running in the write clock domain.
- Keeps an (AWID+1)-bit binary write pointer and publishes it as a registered Gray code (`o_wptr_gray`) for crossing into the read domain.
- There, the Gray code is synchronised and converted back to binary by the downstream Gray-to-binary stage.
- Also synchronises the read-domain Gray pointer into this domain and produces the registered full flag and fill level.

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_sync.sv | 29 ++
 rtl/gray_wptr.sv | 76 +++++++
 tb/tb_gray_wptr.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the dual-clock FIFO pointer stages.
// Helpers work on a fixed 32-bit word; callers zero-extend and slice to their pointer width.
package gray_pkg;

  localparam int unsigned MAX_W = 32;

  typedef logic [MAX_W-1:0] gray_word_t;

  // Pointer width for a given address width: one extra bit for the wrap marker.
  function automatic int unsigned ptr_w(input int unsigned awid);
    return awid + 1;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t v);
    return v ^ (v >> 1);
  endfunction

  // XOR-prefix from the MSB down; zero-extended inputs decode correctly in the low bits.
  function automatic gray_word_t gray2bin(input gray_word_t v);
    gray_word_t b;
    b[MAX_W-1] = v[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ v[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module gray_sync #(
  parameter int unsigned WID         = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] i_d,
  output logic [WID-1:0] o_q
);

  logic [WID-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= i_d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_wptr.sv
// Write-side pointer stage of a dual-clock FIFO: binary/Gray write pointer,
// synchronised read pointer, registered full flag and pessimistic fill level.
module gray_wptr
  import gray_pkg::*;
#(
  parameter int unsigned AWID        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_req,
  output logic                  o_wr_ack,
  output logic [AWID-1:0]       o_waddr,
  output logic [ptr_w(AWID)-1:0] o_wptr_gray,
  input  logic [ptr_w(AWID)-1:0] i_rptr_gray,
  output logic                  o_full,
  output logic [ptr_w(AWID)-1:0] o_level
);

  localparam int unsigned PW = ptr_w(AWID);

  logic          accept;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic [PW-1:0] rq, rbin, full_cmp;
  gray_word_t    wgray_w, rbin_w;
  logic          unused_hi;

  gray_sync #(
    .WID        (PW),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rsync (
    .clk(clk),
    .rst(rst),
    .i_d(i_rptr_gray),
    .o_q(rq)
  );

  always_comb begin
    accept   = i_wr_req & ~full_q;
    wbin_d   = wbin_q + PW'(accept);
    wgray_w  = bin2gray(gray_word_t'(wbin_d));
    wgray_d  = wgray_w[PW-1:0];
    rbin_w   = gray2bin(gray_word_t'(rq));
    rbin     = rbin_w[PW-1:0];
    // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
    full_cmp = {~rq[PW-1:PW-2], rq[PW-3:0]};
    full_d   = (wgray_d == full_cmp);
    level_d  = wbin_d - rbin;
  end

  assign unused_hi = ^{wgray_w[MAX_W-1:PW], rbin_w[MAX_W-1:PW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      level_q <= level_d;
    end
  end

  assign o_wr_ack    = accept;
  assign o_waddr     = wbin_q[AWID-1:0];
  assign o_wptr_gray = wgray_q;
  assign o_full      = full_q;
  assign o_level     = level_q;

endmodule

// File: tb/tb_gray_wptr.sv
// Self-checking bench for gray_wptr against an occupancy-count reference model.
module tb_gray_wptr;

  localparam int unsigned AWID  = 4;
  localparam int unsigned SYNC  = 2;
  localparam int          DEPTH = 16;
  localparam int          MODV  = 32;

  logic       clk;
  logic       rst;
  logic       i_wr_req;
  logic       o_wr_ack;
  logic [3:0] o_waddr;
  logic [4:0] o_wptr_gray;
  logic [4:0] i_rptr_gray;
  logic       o_full;
  logic [4:0] o_level;

  int checks;
  int errors;

  // Reference model: write count and lagged read count, both modulo 2*DEPTH.
  int   m_wcnt;
  int   m_level;
  bit   m_full;
  int   rhist[$];
  logic obs_ack;
  logic exp_ack;

  gray_wptr #(
    .AWID       (AWID),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_req   (i_wr_req),
    .o_wr_ack   (o_wr_ack),
    .o_waddr    (o_waddr),
    .o_wptr_gray(o_wptr_gray),
    .i_rptr_gray(i_rptr_gray),
    .o_full     (o_full),
    .o_level    (o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = 5'(v % MODV);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt  = 0;
    m_level = 0;
    m_full  = 1'b0;
    rhist.delete();
    for (int i = 0; i < int'(SYNC); i++) rhist.push_back(0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_wr_req    = 1'b0;
    i_rptr_gray = 5'd0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Present inputs, capture ack before the edge, clock once, advance the model.
  task automatic drive_edge(input logic req, input int rd_count);
    int rq;
    i_wr_req    = req;
    i_rptr_gray = to_gray(rd_count);
    #1;
    obs_ack = o_wr_ack;
    exp_ack = req && !m_full;
    @(posedge clk);
    #1;
    m_wcnt = (m_wcnt + (exp_ack ? 1 : 0)) % MODV;
    rq = rhist[SYNC-1];
    rhist.push_front(rd_count % MODV);
    void'(rhist.pop_back());
    m_level = (m_wcnt - rq + MODV) % MODV;
    m_full  = (m_level == DEPTH);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive_edge(1'b1, 0);
    #1;
    i_wr_req = 1'b1;
    rst      = 1'b1;
    #1;
    checks++;
    if ({o_wptr_gray, o_waddr, o_full, o_level} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async: got gray=%b waddr=%0d full=%b level=%0d, want all 0",
               o_wptr_gray, o_waddr, o_full, o_level);
    end
    checks++;
    if (o_wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_ack: got %b want 1", o_wr_ack);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_edge(1'b1, 0);
    checks++;
    if (obs_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_ack: got %b want 1", obs_ack);
    end
    checks++;
    if (o_wptr_gray !== 5'b00001 || o_waddr !== 4'd1) begin
      errors++;
      $display("FAIL reset_first_edge: got gray=%b waddr=%0d want 00001/1", o_wptr_gray, o_waddr);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_edge(1'b1, 0);
      checks++;
      if (obs_ack !== 1'b1) begin
        errors++;
        $display("FAIL fill_ack[%0d]: got %b want 1", i, obs_ack);
      end
      checks++;
      if (o_full !== m_full || o_level !== 5'(m_level)) begin
        errors++;
        $display("FAIL fill_state[%0d]: got full=%b level=%0d want %b/%0d",
                 i, o_full, o_level, m_full, m_level);
      end
    end
    checks++;
    if (o_full !== 1'b1 || o_level !== 5'd16 || o_wptr_gray !== 5'b11000) begin
      errors++;
      $display("FAIL fill_full: got full=%b level=%0d gray=%b want 1/16/11000",
               o_full, o_level, o_wptr_gray);
    end
    drive_edge(1'b1, 0);
    checks++;
    if (obs_ack !== 1'b0 || o_wptr_gray !== 5'b11000 || o_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_overreq: got ack=%b gray=%b full=%b want 0/11000/1",
               obs_ack, o_wptr_gray, o_full);
    end
    for (int k = 1; k <= 3; k++) begin
      drive_edge(1'b0, 1);
      checks++;
      if (o_full !== (k < 3) || o_level !== ((k < 3) ? 5'd16 : 5'd15)) begin
        errors++;
        $display("FAIL drain_edge%0d: got full=%b level=%0d", k, o_full, o_level);
      end
    end
    drive_edge(1'b1, 1);
    checks++;
    if (obs_ack !== 1'b1 || o_full !== 1'b1 || o_level !== 5'd16) begin
      errors++;
      $display("FAIL drain_refill: got ack=%b full=%b level=%0d want 1/1/16",
               obs_ack, o_full, o_level);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      checks++;
      if (o_waddr !== 4'(i % DEPTH)) begin
        errors++;
        $display("FAIL wrap_waddr[%0d]: got %0d want %0d", i, o_waddr, i % DEPTH);
      end
      drive_edge(1'b1, (i >= 8) ? i - 8 : 0);
      checks++;
      if (obs_ack !== 1'b1 || o_full !== 1'b0 || o_level !== 5'(m_level)) begin
        errors++;
        $display("FAIL wrap_step[%0d]: got ack=%b full=%b level=%0d want 1/0/%0d",
                 i, obs_ack, o_full, o_level, m_level);
      end
    end
    checks++;
    if (o_wptr_gray !== 5'd0 || o_waddr !== 4'd0) begin
      errors++;
      $display("FAIL wrap_end: got gray=%b waddr=%0d want 0/0", o_wptr_gray, o_waddr);
    end
  endtask

  task automatic test_random();
    int         wtot;
    int         rtot;
    logic [4:0] prev_gray;
    do_reset();
    wtot      = 0;
    rtot      = 0;
    prev_gray = 5'd0;
    for (int n = 0; n < 10000; n++) begin
      if (rtot < wtot && ($urandom % 3) != 0) rtot++;
      drive_edge(1'(($urandom % 4) != 0), rtot);
      if (exp_ack) wtot++;
      checks++;
      if (obs_ack !== exp_ack) begin
        errors++;
        $display("FAIL rand_ack[%0d]: got %b want %b", n, obs_ack, exp_ack);
      end
      checks++;
      if (o_wptr_gray !== to_gray(m_wcnt) || o_waddr !== 4'(m_wcnt % DEPTH)) begin
        errors++;
        $display("FAIL rand_ptr[%0d]: got gray=%b waddr=%0d want %b/%0d",
                 n, o_wptr_gray, o_waddr, to_gray(m_wcnt), m_wcnt % DEPTH);
      end
      checks++;
      if (o_full !== m_full || o_level !== 5'(m_level)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got full=%b level=%0d want %b/%0d",
                 n, o_full, o_level, m_full, m_level);
      end
      checks++;
      if ($countones(o_wptr_gray ^ prev_gray) > 1 || o_level > 5'd16) begin
        errors++;
        $display("FAIL rand_gray_step[%0d]: prev=%b now=%b level=%0d",
                 n, prev_gray, o_wptr_gray, o_level);
      end
      prev_gray = o_wptr_gray;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive_edge(1'b1, 0);
    for (int k = 1; k <= 4; k++) begin
      drive_edge(1'b1, 1);
      checks++;
      if (obs_ack !== exp_ack || o_full !== m_full || o_level !== 5'(m_level)) begin
        errors++;
        $display("FAIL simul_edge%0d: got ack=%b full=%b level=%0d want %b/%b/%0d",
                 k, obs_ack, o_full, o_level, exp_ack, m_full, m_level);
      end
      checks++;
      if (o_level > 5'd16) begin
        errors++;
        $display("FAIL simul_overrun%0d: got level=%0d want <=16", k, o_level);
      end
      if (k == 1) begin
        checks++;
        if (obs_ack !== 1'b0) begin
          errors++;
          $display("FAIL simul_noack: got %b want 0", obs_ack);
        end
      end
      if (k == 3) begin
        checks++;
        if (o_full !== 1'b0 || o_level !== 5'd15) begin
          errors++;
          $display("FAIL simul_drop: got full=%b level=%0d want 0/15", o_full, o_level);
        end
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    i_wr_req    = 1'b0;
    i_rptr_gray = 5'd0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_random();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
